// File: rtl/stack_transfer_sequencer_pkg.sv
// rtl/stack_transfer_sequencer_pkg.sv - shared types and register indices for the PUSH/POP sequencer
package stack_transfer_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PUSH_HI = 3'd1,
    ST_PUSH_LO = 3'd2,
    ST_POP_LO  = 3'd3,
    ST_POP_HI  = 3'd4,
    ST_POP_WB  = 3'd5
  } state_t;

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_t;

  localparam logic [2:0] REG8_W = 3'd0;
  localparam logic [2:0] REG8_Z = 3'd1;
  localparam logic [2:0] REG8_B = 3'd2;
  localparam logic [2:0] REG8_C = 3'd3;
  localparam logic [2:0] REG8_D = 3'd4;
  localparam logic [2:0] REG8_E = 3'd5;
  localparam logic [2:0] REG8_H = 3'd6;
  localparam logic [2:0] REG8_L = 3'd7;

  localparam logic [2:0] REG16_WZ = 3'd0;
  localparam logic [2:0] REG16_BC = 3'd1;
  localparam logic [2:0] REG16_DE = 3'd2;
  localparam logic [2:0] REG16_HL = 3'd3;
  localparam logic [2:0] REG16_SP = 3'd4;
  localparam logic [2:0] REG16_PC = 3'd5;

  // Pair p occupies 8-bit registers 2p (high) and 2p+1 (low).
  function automatic logic [2:0] reg8_index(input logic [1:0] pair, input logic low);
    return {pair, low};
  endfunction

endpackage

// File: rtl/stack_transfer_sequencer_if.sv
// rtl/stack_transfer_sequencer_if.sv - control, register file and memory port bundle of the sequencer
interface stack_transfer_sequencer_if;
  logic        i_Enable;
  logic        i_Start;
  logic        i_Op;
  logic [1:0]  i_Pair;
  logic        o_Busy;
  logic        o_Done;
  logic [7:0]  o_Read8;
  logic [7:0]  o_Write8;
  logic [7:0]  o_Bus8;
  logic [7:0]  i_Bus8;
  logic [5:0]  o_Read16;
  logic [5:0]  o_Write16;
  logic [15:0] o_Bus16;
  logic [15:0] i_Bus16;
  logic [15:0] o_Mem_Addr;
  logic [7:0]  o_Mem_Data;
  logic        o_Mem_Write;
  logic        o_Mem_Read;
  logic [7:0]  i_Mem_Data;

  modport master (
    input  i_Enable, i_Start, i_Op, i_Pair, i_Bus8, i_Bus16, i_Mem_Data,
    output o_Busy, o_Done, o_Read8, o_Write8, o_Bus8, o_Read16, o_Write16,
           o_Bus16, o_Mem_Addr, o_Mem_Data, o_Mem_Write, o_Mem_Read
  );

  modport slave (
    output i_Enable, i_Start, i_Op, i_Pair, i_Bus8, i_Bus16, i_Mem_Data,
    input  o_Busy, o_Done, o_Read8, o_Write8, o_Bus8, o_Read16, o_Write16,
           o_Bus16, o_Mem_Addr, o_Mem_Data, o_Mem_Write, o_Mem_Read
  );
endinterface

// File: rtl/stack_transfer_sequencer.sv
// rtl/stack_transfer_sequencer.sv - PUSH rr / POP rr sequencer moving a register pair through a byte-wide stack port
module stack_transfer_sequencer
  import stack_transfer_sequencer_pkg::*;
(
  input logic                        i_Clk,
  input logic                        i_Reset,
  stack_transfer_sequencer_if.master bus
);

  state_t      state;
  state_t      state_next;
  op_t         op_q;
  logic [1:0]  pair_q;
  logic [2:0]  hi_idx;
  logic [2:0]  lo_idx;
  logic [15:0] sp_dec;
  logic [15:0] sp_inc;
  logic        en;

  assign en     = bus.i_Enable;
  assign hi_idx = reg8_index(pair_q, 1'b0);
  assign lo_idx = reg8_index(pair_q, 1'b1);
  assign sp_dec = bus.i_Bus16 - 16'd1;
  assign sp_inc = bus.i_Bus16 + 16'd1;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state  <= ST_IDLE;
      op_q   <= OP_PUSH;
      pair_q <= 2'd0;
    end else if (en) begin
      state <= state_next;
      if (state == ST_IDLE && bus.i_Start) begin
        op_q   <= op_t'(bus.i_Op);
        pair_q <= bus.i_Pair;
      end
    end
  end

  // A state that disagrees with the latched op can only come from an upset; drop back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (bus.i_Start) state_next = (op_t'(bus.i_Op) == OP_POP) ? ST_POP_LO : ST_PUSH_HI;
      ST_PUSH_HI: state_next = (op_q == OP_PUSH) ? ST_PUSH_LO : ST_IDLE;
      ST_PUSH_LO: state_next = ST_IDLE;
      ST_POP_LO:  state_next = (op_q == OP_POP) ? ST_POP_HI : ST_IDLE;
      ST_POP_HI:  state_next = ST_POP_WB;
      ST_POP_WB:  state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Read selects and data stay valid while disabled; only strobes and done are gated.
  always_comb begin
    bus.o_Busy      = (state != ST_IDLE);
    bus.o_Done      = 1'b0;
    bus.o_Read8     = 8'd0;
    bus.o_Write8    = 8'd0;
    bus.o_Bus8      = 8'd0;
    bus.o_Read16    = 6'd0;
    bus.o_Write16   = 6'd0;
    bus.o_Bus16     = 16'd0;
    bus.o_Mem_Addr  = 16'd0;
    bus.o_Mem_Data  = 8'd0;
    bus.o_Mem_Write = 1'b0;
    bus.o_Mem_Read  = 1'b0;
    case (state)
      ST_PUSH_HI, ST_PUSH_LO: begin
        bus.o_Read16[REG16_SP]  = 1'b1;
        bus.o_Read8[(state == ST_PUSH_HI) ? hi_idx : lo_idx] = 1'b1;
        bus.o_Mem_Addr          = sp_dec;
        bus.o_Mem_Data          = bus.i_Bus8;
        bus.o_Mem_Write         = en;
        bus.o_Write16[REG16_SP] = en;
        bus.o_Bus16             = sp_dec;
        bus.o_Done              = en && (state == ST_PUSH_LO);
      end
      ST_POP_LO, ST_POP_HI: begin
        bus.o_Read16[REG16_SP]  = 1'b1;
        bus.o_Mem_Addr          = bus.i_Bus16;
        bus.o_Mem_Read          = en;
        bus.o_Write16[REG16_SP] = en;
        bus.o_Bus16             = sp_inc;
        if (state == ST_POP_HI) begin
          bus.o_Write8[lo_idx] = en;
          bus.o_Bus8           = bus.i_Mem_Data;
        end
      end
      ST_POP_WB: begin
        bus.o_Write8[hi_idx] = en;
        bus.o_Bus8           = bus.i_Mem_Data;
        bus.o_Done           = en;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/stack_transfer_sequencer.md
# stack_transfer_sequencer

Drives the CPU register file's one-hot read/write select and bus ports to move a 16-bit register pair to and from a byte-wide memory port. It implements the PUSH rr and POP rr data movement. It sits between the instruction control unit, which issues start/op/pair, and the register file plus memory bus. It is the master of the register file interface: it consumes the read buses and produces the write strobes and write data.

## Interface
Parameters: none.

- i_Clk  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Enable  in  1  system tick. When low: FSM frozen and all strobes forced 0.
- i_Start  in  1  request pulse. Accepted only in IDLE with i_Enable=1.
- i_Op  in  1  0=PUSH, 1=POP. Sampled with i_Start.
- i_Pair  in  2  0=WZ, 1=BC, 2=DE, 3=HL. Sampled with i_Start.
- o_Busy  out  1  high in any non-IDLE state.
- o_Done  out  1  high during the final enabled cycle of an operation.
- o_Read8  out  8  one-hot 8-bit register read select (W0 Z1 B2 C3 D4 E5 H6 L7).
- o_Write8  out  8  one-hot 8-bit register write strobe.
- o_Bus8  out  8  byte written to the selected 8-bit register.
- i_Bus8  in  8  byte read from the selected 8-bit register (combinational).
- o_Read16  out  6  one-hot 16-bit read select (WZ0 BC1 DE2 HL3 SP4 PC5). This block uses bit 4 only.
- o_Write16  out  6  one-hot 16-bit write strobe. This block uses bit 4 only.
- o_Bus16  out  16  new SP value.
- i_Bus16  in  16  current SP value (combinational read).
- o_Mem_Addr  out  16  memory byte address.
- o_Mem_Data  out  8  memory write data.
- o_Mem_Write  out  1  memory write strobe.
- o_Mem_Read  out  1  memory read strobe.
- i_Mem_Data  in  8  memory read data. Valid from the clock after a read strobe and held until the next read strobe.

## Operation
- States: IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI, POP_WB.
- Pair mapping: high register index = 2·pair, low register index = 2·pair+1.
- IDLE:
  - All outputs 0.
  - On i_Start & i_Enable, latch op and pair, then go to PUSH_HI (op=0) or POP_LO (op=1).
- PUSH_HI:
  - o_Read16[4]=1, o_Read8[high]=1.
  - o_Mem_Addr = SP−1, o_Mem_Data = i_Bus8, o_Mem_Write=1.
  - o_Write16[4]=1, o_Bus16 = SP−1.
  - Next state: PUSH_LO.
- PUSH_LO:
  - Same as PUSH_HI but using the low register; address and new SP are (current SP)−1.
  - o_Done=1. Next state: IDLE.
- POP_LO:
  - o_Read16[4]=1, o_Mem_Addr = SP, o_Mem_Read=1.
  - o_Write16[4]=1, o_Bus16 = SP+1.
  - Next state: POP_HI.
- POP_HI:
  - Same memory read and SP+1 as POP_LO.
  - Also o_Write8[low]=1, o_Bus8 = i_Mem_Data (the low byte).
  - Next state: POP_WB.
- POP_WB:
  - o_Write8[high]=1, o_Bus8 = i_Mem_Data.
  - o_Done=1. Next state: IDLE.
- Arithmetic: SP ±1 is 16-bit modulo. 0x0000−1 = 0xFFFF; 0xFFFF+1 = 0x0000.
- Select vectors are at most one-hot at all times. Unused select bits are 0.
- i_Start while busy: ignored, no queuing.
- Popping into WZ/BC/DE/HL uses only 8-bit strobes. o_Write16[0..3] is never asserted.

## Timing
- Reset: state=IDLE, latched op/pair = 0, and every output 0.
- Reset mid-operation:
  - Abort immediately; the next cycle is IDLE with no strobes.
  - SP and register writes already committed stay committed.
- Latency from i_Start cycle to o_Done cycle, with i_Enable continuously high:
  - PUSH: 2 cycles (done in 2nd cycle after start).
  - POP: 3 cycles.
- i_Enable low:
  - State, op and pair hold. Read selects stay valid; all write/read strobes and o_Done are 0.
  - The operation resumes on the next enabled cycle.
- Outputs are combinational from state, the latched pair, and the i_Bus16/i_Bus8/i_Mem_Data inputs. There are no registered datapath outputs.
- A new i_Start is accepted in the IDLE cycle immediately following o_Done.

## Structure
- Shared package holds:
  - state enum.
  - op encoding (OP_PUSH=0, OP_POP=1).
  - register index constants REG8_W..REG8_L and REG16_WZ..REG16_PC.
- No sub-module is natural. The ±1 adder and the one-hot decode are inline.

## Test plan
- PUSH BC, SP=0xFFFE, B=0x12, C=0x34 -> writes 0x12@0xFFFD then 0x34@0xFFFC; SP=0xFFFC; o_Done in cycle 2.
- POP DE, SP=0xC000, mem[0xC000]=0xCD, mem[0xC001]=0xAB -> E=0xCD, D=0xAB, SP=0xC002; o_Done in cycle 3.
- PUSH HL with SP=0x0001 -> addresses 0x0000 then 0xFFFF; SP=0xFFFF (wrap).
- POP WZ with i_Enable low for 2 cycles after POP_LO -> no strobes while low; result W/Z correct; o_Done delayed by exactly 2 cycles.
- i_Start during PUSH -> ignored. i_Reset asserted in POP_HI -> next cycle IDLE, all outputs 0, D/H unchanged, SP = pre-pop+1 or +2 per committed cycles.
- Every cycle: o_Read8/o_Write8/o_Read16/o_Write16 each have zero or one bit set (assertion).
